// File: rtl/eth_tx_bitorder_fcs.sv
// RMII TX back end: re-orders MSb-first input dibits to LSb-first, appends the
// CRC-32 FCS over post-preamble bytes, then holds the line idle for the IPG.
module eth_tx_bitorder_fcs #(
  parameter int PREAMBLE_BYTES = 8,
  parameter int IPG_DIBITS     = 48
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       axiiv,
  input  logic [1:0] axiid,
  output logic       axiov,
  output logic [1:0] axiod,
  output logic       frame_done,
  output logic       overrun
);
  typedef enum logic [1:0] {IDLE, PASS, FCS, IPG} state_t;

  localparam int BCW = $clog2(PREAMBLE_BYTES + 2);
  localparam int ICW = $clog2(IPG_DIBITS + 1);
  localparam logic [BCW-1:0] PRE      = BCW'(PREAMBLE_BYTES);
  localparam logic [ICW-1:0] IPG_LAST = ICW'(IPG_DIBITS - 1);

  state_t         state;
  logic [1:0]     in_ph, o_ph, pend;
  logic [5:0]     asm_q;
  logic [7:0]     obuf [2];
  logic           wsel, rsel, draining, ign;
  logic [BCW-1:0] byte_cnt;
  logic [31:0]    crc, fcs;
  logic [3:0]     fcs_cnt;
  logic [ICW-1:0] ipg_cnt;
  logic [7:0]     new_byte;
  logic           push, pop;

  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] r;
    r = c ^ {24'd0, b};
    for (int i = 0; i < 8; i++) r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    return r;
  endfunction

  always_comb begin
    new_byte = {asm_q, axiid};
    push     = (state == PASS) && !draining && axiiv && (in_ph == 2'd3);
    pop      = (pend != 2'd0) && (o_ph == 2'd3);
    fcs      = ~crc;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      axiov      <= 1'b0;
      axiod      <= 2'd0;
      frame_done <= 1'b0;
      overrun    <= 1'b0;
      in_ph      <= 2'd0;
      o_ph       <= 2'd0;
      pend       <= 2'd0;
      asm_q      <= 6'd0;
      obuf[0]    <= 8'd0;
      obuf[1]    <= 8'd0;
      wsel       <= 1'b0;
      rsel       <= 1'b0;
      draining   <= 1'b0;
      ign        <= 1'b0;
      byte_cnt   <= '0;
      crc        <= 32'hFFFFFFFF;
      fcs_cnt    <= 4'd0;
      ipg_cnt    <= '0;
    end else begin
      frame_done <= 1'b0;
      overrun    <= 1'b0;

      // A frame that starts while we cannot accept it is swallowed whole.
      if (!axiiv) ign <= 1'b0;
      else if (!ign && (state == FCS || state == IPG || (state == PASS && draining))) begin
        ign     <= 1'b1;
        overrun <= 1'b1;
      end

      if (pend != 2'd0) begin
        axiov <= 1'b1;
        axiod <= obuf[rsel][{o_ph, 1'b0} +: 2];
        o_ph  <= o_ph + 1'b1;
        if (o_ph == 2'd3) rsel <= ~rsel;
      end else if (state != FCS) begin
        axiov <= 1'b0;
        axiod <= 2'd0;
      end
      pend <= pend + {1'b0, push} - {1'b0, pop};

      if (push) begin
        obuf[wsel] <= new_byte;
        wsel       <= ~wsel;
        if (byte_cnt >= PRE) crc <= crc_byte(crc, new_byte);
        if (byte_cnt <= PRE) byte_cnt <= byte_cnt + 1'b1;
      end

      case (state)
        IDLE: if (axiiv && !ign) begin
          state    <= PASS;
          asm_q    <= {asm_q[3:0], axiid};
          in_ph    <= 2'd1;
          crc      <= 32'hFFFFFFFF;
          byte_cnt <= '0;
          draining <= 1'b0;
        end
        PASS: begin
          if (!draining && axiiv) begin
            asm_q <= {asm_q[3:0], axiid};
            in_ph <= in_ph + 1'b1;
          end else begin
            if (!draining) begin
              in_ph    <= 2'd0;
              draining <= 1'b1;
              if (in_ph != 2'd0) overrun <= 1'b1;
            end
            // FCS must start right behind the last data dibit, no gap.
            if (byte_cnt == '0) begin
              state    <= IDLE;
              draining <= 1'b0;
            end else if (pop && pend == 2'd1) begin
              state    <= FCS;
              fcs_cnt  <= 4'd0;
              draining <= 1'b0;
            end
          end
        end
        FCS: begin
          axiov   <= 1'b1;
          axiod   <= fcs[{fcs_cnt, 1'b0} +: 2];
          fcs_cnt <= fcs_cnt + 1'b1;
          if (fcs_cnt == 4'd15) begin
            frame_done <= 1'b1;
            state      <= IPG;
            ipg_cnt    <= '0;
          end
        end
        IPG: begin
          ipg_cnt <= ipg_cnt + 1'b1;
          if (ipg_cnt == IPG_LAST) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
